// File: rtl/qam_frame_ctrl.sv
// qam_frame_ctrl: frames payload bytes into 16-QAM symbols (high nibble first)
// and supervises the mapper handshake with a done timeout.
// Optional feature: define QAM_PREAMBLE_EN to emit the F,0,F,0 preamble
// between the start pulse and the first payload symbol.
module qam_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] frame_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       qam_start,
    output logic [3:0] qam_symbol,
    output logic       qam_valid,
    output logic       qam_last,
    input  logic       map_done,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned SYM_W = 4;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
`ifdef QAM_PREAMBLE_EN
        S_PRE   = 3'd2,
`endif
        S_HI    = 3'd3,
        S_LO    = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [SYM_W-1:0]   lo_nib_q, lo_nib_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               zero_done_q, zero_done_d;
`ifdef QAM_PREAMBLE_EN
    logic [1:0]         pre_q, pre_d;
`endif

    logic accept_go;
    logic timeout_hit;

    assign accept_go   = (state_q == S_IDLE) && go && (frame_len != '0);
    assign timeout_hit = (state_q == S_WAIT) && !map_done && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: byte counter, low nibble, held symbol, timeout, flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q       <= '0;
            lo_nib_q    <= '0;
            sym_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
`ifdef QAM_PREAMBLE_EN
            pre_q       <= '0;
`endif
        end else begin
            rem_q       <= rem_d;
            lo_nib_q    <= lo_nib_d;
            sym_q       <= sym_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            zero_done_q <= zero_done_d;
`ifdef QAM_PREAMBLE_EN
            pre_q       <= pre_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_go) state_d = S_START;
`ifdef QAM_PREAMBLE_EN
            S_START: state_d = S_PRE;
            S_PRE:   if (pre_q == 2'd3) state_d = S_HI;
`else
            S_START: state_d = S_HI;
`endif
            S_HI:    if (in_valid) state_d = S_LO;
            S_LO:    state_d = (rem_q == LEN_W'(1)) ? S_WAIT : S_HI;
            S_WAIT: begin
                // done wins over a timeout expiring in the same cycle
                if (map_done)         state_d = S_DONE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        rem_d       = rem_q;
        lo_nib_d    = lo_nib_q;
        tmo_d       = '0;
        err_d       = err_q;
        zero_done_d = (state_q == S_IDLE) && go && (frame_len == '0);
        // remember the last symbol driven so stalls hold it on the bus
        sym_d       = qam_valid ? qam_symbol : sym_q;
`ifdef QAM_PREAMBLE_EN
        pre_d       = '0;
        if (state_q == S_PRE) pre_d = pre_q + 2'd1;
`endif
        if (accept_go) begin
            rem_d = frame_len;
            err_d = 1'b0;
        end
        if ((state_q == S_HI) && in_valid) lo_nib_d = in_data[3:0];
        if (state_q == S_LO) rem_d = rem_q - LEN_W'(1);
        if (state_q == S_WAIT) tmo_d = tmo_q + TMO_W'(1);
        if (timeout_hit) err_d = 1'b1;
    end

    // Output decode; HI forwards the high nibble in the accepting cycle
    always_comb begin
        in_ready   = 1'b0;
        qam_start  = 1'b0;
        qam_valid  = 1'b0;
        qam_last   = 1'b0;
        qam_symbol = sym_q;
        frame_done = zero_done_q;
        busy       = (state_q != S_IDLE);
        err        = err_q;
        case (state_q)
            S_START: qam_start = 1'b1;
`ifdef QAM_PREAMBLE_EN
            S_PRE: begin
                qam_valid  = 1'b1;
                qam_symbol = pre_q[0] ? 4'h0 : 4'hF;
            end
`endif
            S_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    qam_valid  = 1'b1;
                    qam_symbol = in_data[7:4];
                end
            end
            S_LO: begin
                qam_valid  = 1'b1;
                qam_symbol = lo_nib_q;
                qam_last   = (rem_q == LEN_W'(1));
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule
